// File: rtl/comp2_serial_cascade_if.sv
// Handshake bundle between a comp2 bit source, the serial cascade stage and the result consumer.
interface comp2_serial_cascade_if;
  logic in_valid;
  logic in_ready;
  logic in_l;
  logic in_e;
  logic in_g;
  logic out_valid;
  logic out_ready;
  logic out_lt;
  logic out_eq;
  logic out_gt;
  logic out_err;

  modport slave (
    input  in_valid, in_l, in_e, in_g, out_ready,
    output in_ready, out_valid, out_lt, out_eq, out_gt, out_err
  );

  modport master (
    output in_valid, in_l, in_e, in_g, out_ready,
    input  in_ready, out_valid, out_lt, out_eq, out_gt, out_err
  );
endinterface

// File: rtl/comp2_serial_cascade.sv
// Bit-serial MSB-first cascade of comp2 L/E/G outputs into a WIDTH-bit lt/eq/gt result.
module comp2_serial_cascade #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  comp2_serial_cascade_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  typedef enum logic [1:0] {UNDEC, DEC_LT, DEC_GT} dec_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  dec_t             dec_q, dec_d, dec_n;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d, err_n;
  logic             valid_q, valid_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             oerr_q, oerr_d;
  logic             accept;
  logic             legal;

  assign bus.in_ready  = !valid_q;
  assign bus.out_valid = valid_q;
  assign bus.out_lt    = lt_q;
  assign bus.out_eq    = eq_q;
  assign bus.out_gt    = gt_q;
  assign bus.out_err   = oerr_q;

  always_comb begin
    accept  = bus.in_valid && !valid_q;
    legal   = ({bus.in_l, bus.in_e, bus.in_g} == 3'b100) ||
              ({bus.in_l, bus.in_e, bus.in_g} == 3'b010) ||
              ({bus.in_l, bus.in_e, bus.in_g} == 3'b001);
    state_d = state_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    err_d   = err_q;
    valid_d = valid_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    oerr_d  = oerr_q;

    // Effect of the current bit on decision/error, applied only when it is accepted.
    dec_n = dec_q;
    err_n = err_q || !legal;
    if (legal && dec_q == UNDEC) begin
      if (bus.in_l)      dec_n = DEC_LT;
      else if (bus.in_g) dec_n = DEC_GT;
    end

    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          dec_d = dec_n;
          err_d = err_n;
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            valid_d = 1'b1;
            lt_d    = (dec_n == DEC_LT);
            eq_d    = (dec_n == UNDEC);
            gt_d    = (dec_n == DEC_GT);
            oerr_d  = err_n;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
          dec_d   = UNDEC;
          err_d   = 1'b0;
          valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      dec_d   = UNDEC;
      err_d   = 1'b0;
      valid_d = 1'b0;
      lt_d    = 1'b0;
      eq_d    = 1'b0;
      gt_d    = 1'b0;
      oerr_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dec_q   <= UNDEC;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      oerr_q  <= oerr_d;
    end
  end

endmodule

// File: doc/comp2_serial_cascade.md
# comp2_serial_cascade

Bit-serial cascade stage that sits directly downstream of the single-bit `comp2` comparator cell. It consumes the per-bit L/E/G outputs of `comp2`, presented MSB-first one bit per handshake, and resolves a WIDTH-bit magnitude comparison of the operands A and B. The result is presented as a one-hot lt/eq/gt word on a valid/ready output. This lets multi-bit comparisons, which the `comp2` techmap rejects, be built from a single `comp2` instance plus a shift source.

## Interface
- `WIDTH`, default 8: operand width, i.e. number of bit-compares per word; legal range 1..255.
- `CNT_W`, default `$clog2(WIDTH+1)`: width of the internal bit counter. Derived; do not override.

Ports:
- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `flush`, in, 1: synchronous abort. Discards the partial word and any pending result.
- `in_valid`, in, 1: the current `in_l`/`in_e`/`in_g` bit is valid.
- `in_ready`, out, 1: the block accepts a bit this cycle.
- `in_l`, in, 1: `comp2` L output for the current bit (A<B).
- `in_e`, in, 1: `comp2` E output for the current bit (A==B).
- `in_g`, in, 1: `comp2` G output for the current bit (A>B).
- `out_valid`, out, 1: result word is valid.
- `out_ready`, in, 1: downstream accepts the result.
- `out_lt`, out, 1: A<B over the WIDTH bits.
- `out_eq`, out, 1: A==B over the WIDTH bits.
- `out_gt`, out, 1: A>B over the WIDTH bits.
- `out_err`, out, 1: at least one bit of this word had a non-one-hot L/E/G pattern.

## Operation
- **Bit acceptance.** A bit is accepted when `in_valid && in_ready`.
- **Bit order.** Bits arrive MSB first. The first accepted bit after reset, after `flush`, or after a result handoff is the MSB of a new word.
- **States:**
  - IDLE: `cnt`=0, decision undecided.
  - ACCUM: 0<`cnt`<WIDTH.
  - DONE: result held.
- **Transitions:**
  - IDLE→ACCUM on accept.
  - ACCUM→DONE on the accept that makes `cnt`==WIDTH.
  - IDLE→DONE directly when WIDTH=1.
  - DONE→IDLE on `out_valid && out_ready`.
- **Decision rule (first difference wins).** While the word is undecided:
  - An accepted bit with `in_l` only sets decided=LT.
  - An accepted bit with `in_g` only sets decided=GT.
  - An accepted bit with `in_e` only leaves the word undecided.
  - Once decided, later bits never change the decision; they are still counted.
- **Illegal input.** An accepted bit whose {`in_l`,`in_e`,`in_g`} is not exactly one-hot:
  - sets the sticky word error flag;
  - does not change the decision;
  - is counted.
- **Result on entering DONE:**
  - `out_lt`/`out_gt` reflect the decision.
  - `out_eq`=1 iff the word is still undecided.
  - Exactly one of the three is high.
  - `out_err` = the sticky flag.
- **Input ready.** `in_ready` = !`out_valid`. There is no same-cycle bypass: no bit is accepted in the cycle the result is popped.
- **Result stability.** Result outputs are stable while `out_valid && !out_ready`.
- **Flush.**
  - `flush` returns the block to IDLE next cycle: `cnt`=0, undecided, err cleared, `out_valid`=0.
  - `flush` beats a simultaneous bit accept and a simultaneous result handoff; the popped or accepted data is discarded.
- **Reset.** `rst_n`=0 at an edge forces the same state as `flush`. Reset has priority over `flush`.

## Timing
- **Reset values:**
  - `in_ready`=1
  - `out_valid`=0
  - `out_lt`=0, `out_eq`=0, `out_gt`=0
  - `out_err`=0
- **Latency.** `out_valid` rises in the cycle after the edge that accepts bit WIDTH-1 (the LSB).
- **Throughput.** At best WIDTH+1 cycles per word: WIDTH accept cycles plus one DONE cycle with `out_ready`=1.
- **Output registering.** All outputs are registered except `in_ready`, which is a combinational inverse of the `out_valid` register.
- **Counter.** `cnt` never wraps past WIDTH. It clears on handoff, `flush`, or reset.
- **Input stalls.** `in_valid` gaps mid-word are allowed and leave all state unchanged.

## Test plan
- **GT case.** WIDTH=4, A=1010, B=1001, bits E,E,G,L back-to-back, `out_ready`=1 → `out_valid` one cycle after the 4th accept with `out_gt`=1, `out_lt`=`out_eq`=`out_err`=0. `in_ready` is low for exactly that one cycle.
- **EQ case.** WIDTH=4, all four bits E → `out_eq`=1. With `in_valid` gapped 2 cycles between bits, the result is unchanged and appears one cycle after the last accept.
- **First difference wins.** WIDTH=4, bits L,G,G,G → `out_lt`=1. A second word E,E,E,G sent immediately after handoff → `out_gt`=1, showing no state leaks between words.
- **Backpressure.** Hold `out_ready`=0 for 5 cycles after DONE → `out_valid` and the result stay constant, `in_ready`=0, and `in_valid` pulses are ignored. Raise `out_ready` → handoff happens, then the next bit is accepted the following cycle.
- **Flush / reset.** Assert `flush` after 2 of 4 bits, then send G,E,E,E → `out_gt`=1 (the partial word is discarded). Repeat with `rst_n`=0 mid-word → all outputs return to their reset values on the next edge.
- **Illegal patterns.** WIDTH=4, bits E,{L,G both high},E,E → `out_eq`=1, `out_err`=1. The next word E,E,E,E → `out_err`=0. WIDTH=1 with a single G → DONE in one accept, `out_gt`=1.
